// File: rtl/sram_bus_ctrl_pkg.sv
`default_nettype none
// ======================================================================
// sram_bus_ctrl_pkg : memory map, store FSM states, byte-lane helpers
// Revision 1.0
// ======================================================================
package sram_bus_ctrl_pkg;

  localparam logic [31:0] DEF_BASE_START = 32'h8000_0000;
  localparam logic [31:0] DEF_EXT_START  = 32'h8040_0000;
  localparam logic [31:0] DEF_EXT_END    = 32'h8080_0000;
  localparam logic [31:0] DEF_UART_DATA  = 32'hBFD0_03F8;
  localparam logic [31:0] DEF_UART_STAT  = 32'hBFD0_03FC;

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RECOVER = 2'd2
  } wr_state_e;

  // Byte loads return the selected lane sign-extended; anything else is a word.
  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [3:0] sel);
    case (sel)
      SEL_B0:  return {{24{w[7]}},  w[7:0]};
      SEL_B1:  return {{24{w[15]}}, w[15:8]};
      SEL_B2:  return {{24{w[23]}}, w[23:16]};
      SEL_B3:  return {{24{w[31]}}, w[31:24]};
      default: return w;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bus_ctrl_sram_port.sv
`default_nettype none
// ======================================================================
// sram_port : tri-state data and active-low control driver for one SRAM
// Revision 1.0
// ======================================================================
module sram_port (
  input  logic        ce_i,
  input  logic        oe_i,
  input  logic        we_i,
  input  logic        drv_i,
  input  logic [19:0] addr_i,
  input  logic [3:0]  be_n_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  inout  wire  [31:0] ram_data,
  output logic [19:0] ram_addr,
  output logic [3:0]  ram_be_n,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  assign ram_data = drv_i ? wdata_i : {32{1'bz}};
  assign rdata_o  = ram_data;
  assign ram_addr = addr_i;
  assign ram_ce_n = ~ce_i;
  // Output enable is forced off whenever we drive, so the bus never fights the chip.
  assign ram_oe_n = ~(ce_i & oe_i & ~drv_i);
  assign ram_we_n = ~(ce_i & we_i);
  assign ram_be_n = ce_i ? be_n_i : 4'hF;

endmodule
`default_nettype wire

// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ======================================================================
// sram_bus_ctrl : base/ext SRAM and UART access for the IF and MEM stages
// Revision 1.0
// ======================================================================
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_START = DEF_BASE_START,
  parameter logic [31:0] EXT_START  = DEF_EXT_START,
  parameter logic [31:0] EXT_END    = DEF_EXT_END,
  parameter logic [31:0] UART_DATA  = DEF_UART_DATA,
  parameter logic [31:0] UART_STAT  = DEF_UART_STAT,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] ram_data_o,
  output logic        stallreq_o,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic        uart_tx_start_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_tx_busy_i,
  input  logic        uart_rx_ready_i,
  input  logic [7:0]  uart_rx_data_i,
  output logic        uart_rx_clear_o
);

  wr_state_e   state_q;
  logic [1:0]  cnt_q;
  logic        wr_we_q, wr_drv_q, wr_ext_q;
  logic [19:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_be_n_q;
  logic        done_q, key_we_q;
  logic [31:0] key_addr_q, key_data_q;
  logic        tx_start_q, rx_clear_q;
  logic [7:0]  tx_data_q;

  logic w_base, w_ext, w_udata, w_ustat, w_sram;
  logic w_same, w_new, w_busy;
  logic w_base_wr, w_ext_wr, w_base_mem, w_ext_rd;
  logic [31:0] w_base_rdata, w_ext_rdata;
  logic w_unused_ok;

  assign w_base  = (mem_addr_i >= BASE_START) && (mem_addr_i < EXT_START);
  assign w_ext   = (mem_addr_i >= EXT_START) && (mem_addr_i < EXT_END);
  assign w_udata = (mem_addr_i == UART_DATA);
  assign w_ustat = (mem_addr_i == UART_STAT);
  assign w_sram  = w_base || w_ext;

  // A side-effecting request already serviced stays suppressed while MEM holds it.
  assign w_same = done_q && mem_ce_i && (mem_addr_i == key_addr_q) && (mem_we_i == key_we_q)
                  && (!mem_we_i || (mem_data_i == key_data_q));
  assign w_new  = mem_ce_i && !w_same;
  assign w_busy = (state_q != S_IDLE);

  assign w_base_wr  = wr_drv_q && !wr_ext_q;
  assign w_ext_wr   = wr_drv_q && wr_ext_q;
  assign w_base_mem = mem_ce_i && w_base;
  assign w_ext_rd   = mem_ce_i && !mem_we_i && w_ext && !w_ext_wr;

  sram_port u_base (
    .ce_i     (rst),
    .oe_i     (rst && !w_base_wr),
    .we_i     (rst && w_base_wr && wr_we_q),
    .drv_i    (rst && w_base_wr),
    .addr_i   (w_base_wr ? wr_addr_q : (w_base_mem ? mem_addr_i[21:2] : inst_addr_i[21:2])),
    .be_n_i   (w_base_wr ? wr_be_n_q : 4'b0000),
    .wdata_i  (wr_data_q),
    .rdata_o  (w_base_rdata),
    .ram_data (base_ram_data),
    .ram_addr (base_ram_addr),
    .ram_be_n (base_ram_be_n),
    .ram_ce_n (base_ram_ce_n),
    .ram_oe_n (base_ram_oe_n),
    .ram_we_n (base_ram_we_n)
  );

  sram_port u_ext (
    .ce_i     (rst && (w_ext_wr || w_ext_rd)),
    .oe_i     (w_ext_rd),
    .we_i     (w_ext_wr && wr_we_q),
    .drv_i    (rst && w_ext_wr),
    .addr_i   (w_ext_wr ? wr_addr_q : mem_addr_i[21:2]),
    .be_n_i   (w_ext_wr ? wr_be_n_q : 4'b0000),
    .wdata_i  (wr_data_q),
    .rdata_o  (w_ext_rdata),
    .ram_data (ext_ram_data),
    .ram_addr (ext_ram_addr),
    .ram_be_n (ext_ram_be_n),
    .ram_ce_n (ext_ram_ce_n),
    .ram_oe_n (ext_ram_oe_n),
    .ram_we_n (ext_ram_we_n)
  );

  assign inst_o = (w_base_mem || w_base_wr) ? 32'h0 : w_base_rdata;

  always_comb begin
    ram_data_o = 32'h0;
    if (mem_ce_i && !mem_we_i) begin
      if (w_sram)
        ram_data_o = load_lane(w_base ? w_base_rdata : w_ext_rdata, mem_sel_i);
      else if (w_ustat)
        ram_data_o = {30'b0, uart_rx_ready_i, ~uart_tx_busy_i};
      else if (w_udata)
        ram_data_o = {24'b0, uart_rx_data_i};
    end
  end

  assign stallreq_o      = rst && (w_busy || (w_new && mem_we_i && w_sram));
  assign uart_tx_start_o = tx_start_q;
  assign uart_tx_data_o  = tx_data_q;
  assign uart_rx_clear_o = rx_clear_q;
  assign w_unused_ok     = ^{inst_addr_i[31:22], inst_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      wr_we_q    <= 1'b0;
      wr_drv_q   <= 1'b0;
      wr_ext_q   <= 1'b0;
      wr_addr_q  <= 20'h0;
      wr_data_q  <= 32'h0;
      wr_be_n_q  <= 4'hF;
      done_q     <= 1'b0;
      key_we_q   <= 1'b0;
      key_addr_q <= 32'h0;
      key_data_q <= 32'h0;
      tx_start_q <= 1'b0;
      rx_clear_q <= 1'b0;
      tx_data_q  <= 8'h0;
    end else begin
      tx_start_q <= 1'b0;
      rx_clear_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          done_q <= w_same;
          if (w_new && mem_we_i && w_sram) begin
            state_q    <= S_WRITE;
            cnt_q      <= 2'd0;
            wr_we_q    <= 1'b1;
            wr_drv_q   <= 1'b1;
            wr_ext_q   <= w_ext;
            wr_addr_q  <= mem_addr_i[21:2];
            wr_data_q  <= mem_data_i;
            wr_be_n_q  <= ~mem_sel_i;
            done_q     <= 1'b0;
            key_we_q   <= 1'b1;
            key_addr_q <= mem_addr_i;
            key_data_q <= mem_data_i;
          end else if (w_new && w_udata) begin
            done_q     <= 1'b1;
            key_we_q   <= mem_we_i;
            key_addr_q <= mem_addr_i;
            key_data_q <= mem_data_i;
            if (!mem_we_i) begin
              rx_clear_q <= 1'b1;
            end else if (!uart_tx_busy_i) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= mem_data_i[7:0];
            end
          end
        end
        S_WRITE: begin
          if (cnt_q == 2'(WR_CYCLES - 1)) begin
            state_q <= S_RECOVER;
            wr_we_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_RECOVER: begin
          state_q  <= S_IDLE;
          wr_drv_q <= 1'b0;
          done_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
`default_nettype none
// ======================================================================
// tb_sram_bus_ctrl : scoreboard bench with SRAM models for both chips
// Revision 1.0
// ======================================================================
module tb_sram_bus_ctrl;

  localparam int WR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_data;
  logic [3:0]  mem_sel;
  logic        tx_busy, rx_ready;
  logic [7:0]  rx_data;
  wire  [31:0] inst_o, ram_data_o;
  wire         stallreq_o;
  wire  [31:0] base_ram_data, ext_ram_data;
  wire  [19:0] base_ram_addr, ext_ram_addr;
  wire  [3:0]  base_ram_be_n, ext_ram_be_n;
  wire         base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  wire         ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  wire         uart_tx_start_o, uart_rx_clear_o;
  wire  [7:0]  uart_tx_data_o;

  sram_bus_ctrl #(.WR_CYCLES(WR)) dut (
    .clk(clk), .rst(rst), .inst_addr_i(inst_addr), .inst_o(inst_o),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_sel_i(mem_sel),
    .mem_data_i(mem_data), .ram_data_o(ram_data_o), .stallreq_o(stallreq_o),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_tx_start_o(uart_tx_start_o), .uart_tx_data_o(uart_tx_data_o), .uart_tx_busy_i(tx_busy),
    .uart_rx_ready_i(rx_ready), .uart_rx_data_i(rx_data), .uart_rx_clear_o(uart_rx_clear_o)
  );

  always #5 clk = ~clk;

  logic [31:0] base_mem [0:1023];
  logic [31:0] ext_mem  [0:1023];

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[9:0]] : {32{1'bz}};
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[9:0]] : {32{1'bz}};

  always @(posedge clk) begin
    if (!rst) begin
      base_mem[0]     <= 32'h1122_3344;
      base_mem[10'h40] <= 32'hCAFE_F00D;
      ext_mem[4]      <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
          base_mem[base_ram_addr[9:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
        if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
          ext_mem[ext_ram_addr[9:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    mem_ce = 1'b0;
    mem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp, input string tag);
    exp_t e;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = a; mem_sel = s;
    sb.push_back('{tag, exp});
    #1;
    e = sb.pop_front();
    check(e.tag, ram_data_o, e.val);
  endtask

  task automatic sram_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit ext, input logic [19:0] exp_addr, input logic [3:0] exp_ben,
                            input string tag);
    int wel, stl;
    bit fin, seen;
    wel = 0; stl = 0; fin = 0; seen = 0;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = a; mem_data = d; mem_sel = s;
    #1 check({tag, "_req_stall"}, stallreq_o, 1);
    for (int i = 0; i < 12 && !fin; i++) begin
      @(negedge clk);
      if ((ext ? ext_ram_we_n : base_ram_we_n) == 1'b0) begin
        wel++;
        if (!seen) begin
          seen = 1;
          check({tag, "_addr"}, ext ? ext_ram_addr : base_ram_addr, exp_addr);
          check({tag, "_be_n"}, ext ? ext_ram_be_n : base_ram_be_n, exp_ben);
          check({tag, "_ce_n"}, ext ? ext_ram_ce_n : base_ram_ce_n, 0);
          check({tag, "_oe_n"}, ext ? ext_ram_oe_n : base_ram_oe_n, 1);
          check({tag, "_bus"}, ext ? ext_ram_data : base_ram_data, d);
          if (!ext) check({tag, "_inst_nop"}, inst_o, 0);
        end
      end
      if (stallreq_o) stl++;
      else fin = 1;
    end
    check({tag, "_finished"}, fin, 1);
    check({tag, "_we_cycles"}, wel, WR);
    check({tag, "_stall_after_req"}, stl, WR + 1);
    @(negedge clk);
    check({tag, "_no_retrigger_we"}, ext ? ext_ram_we_n : base_ram_we_n, 1);
    check({tag, "_no_retrigger_stall"}, stallreq_o, 0);
    idle();
  endtask

  task automatic hold_count(input int n, output int tx_n, output int rx_n, output int st_n, output int wel);
    tx_n = 0; rx_n = 0; st_n = 0; wel = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx_start_o) tx_n++;
      if (uart_rx_clear_o) rx_n++;
      if (stallreq_o) st_n++;
      if (!base_ram_we_n || !ext_ram_we_n) wel++;
    end
  endtask

  int tx_n, rx_n, st_n, wel;

  initial begin
    rst = 1'b0; inst_addr = 32'h8000_0000;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_data = 32'h0; mem_sel = 4'h0;
    tx_busy = 1'b0; rx_ready = 1'b0; rx_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_base_ce_n", base_ram_ce_n, 1);
    check("rst_base_oe_n", base_ram_oe_n, 1);
    check("rst_base_we_n", base_ram_we_n, 1);
    check("rst_base_be_n", base_ram_be_n, 4'hF);
    check("rst_ext_ce_n", ext_ram_ce_n, 1);
    check("rst_ext_we_n", ext_ram_we_n, 1);
    check("rst_ext_be_n", ext_ram_be_n, 4'hF);
    check("rst_stall", stallreq_o, 0);
    check("rst_tx_start", uart_tx_start_o, 0);
    check("rst_rx_clear", uart_rx_clear_o, 0);
    rst = 1'b1;
    @(negedge clk);

    inst_addr = 32'h8000_0100;
    #1;
    check("fetch_addr", base_ram_addr, 20'h00040);
    check("fetch_oe_n", base_ram_oe_n, 0);
    check("fetch_inst", inst_o, 32'hCAFE_F00D);
    @(negedge clk);

    sram_store(32'h8040_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, 20'h00004, 4'b0000, "sw_ext");
    load(32'h8040_0010, 4'b1111, 32'hDEAD_BEEF, "lw_ext");
    idle();

    sram_store(32'h8000_0003, 32'h8080_8080, 4'b1000, 1'b0, 20'h00000, 4'b0111, "sb_base");
    load(32'h8000_0003, 4'b1000, 32'hFFFF_FF80, "lb_base_neg");
    check("lb_inst_nop", inst_o, 32'h0);
    idle();
    load(32'h8000_0000, 4'b1111, 32'h8022_3344, "lw_base_after_sb");
    idle();
    load(32'h8000_0002, 4'b0100, 32'h0000_0022, "lb_base_pos");
    idle();

    rx_ready = 1'b1; tx_busy = 1'b0;
    load(32'hBFD0_03FC, 4'b1111, 32'h3, "uart_stat_ready");
    idle();
    rx_ready = 1'b0; tx_busy = 1'b1;
    load(32'hBFD0_03FC, 4'b1111, 32'h0, "uart_stat_busy");
    idle();

    tx_busy = 1'b0;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'hBFD0_03F8; mem_data = 32'h4141_4141; mem_sel = 4'b0001;
    hold_count(4, tx_n, rx_n, st_n, wel);
    check("uart_tx_pulses", tx_n, 1);
    check("uart_tx_data", uart_tx_data_o, 8'h41);
    check("uart_tx_stall", st_n, 0);
    idle();
    tx_busy = 1'b1;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'hBFD0_03F8; mem_data = 32'h4242_4242; mem_sel = 4'b0001;
    hold_count(4, tx_n, rx_n, st_n, wel);
    check("uart_tx_busy_drop", tx_n, 0);
    check("uart_tx_data_kept", uart_tx_data_o, 8'h41);
    idle();
    tx_busy = 1'b0;

    rx_data = 8'h5A; rx_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load(32'hBFD0_03F8, 4'b0001, 32'h0000_005A, "uart_rx_data");
      hold_count(4, tx_n, rx_n, st_n, wel);
      check("uart_rx_clear_pulses", rx_n, 1);
      idle();
    end

    load(32'h9000_0000, 4'b1111, 32'h0, "unmapped_lw");
    idle();
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h9000_0000; mem_data = 32'h1234_5678; mem_sel = 4'b1111;
    #1 check("unmapped_sw_req_stall", stallreq_o, 0);
    hold_count(4, tx_n, rx_n, st_n, wel);
    check("unmapped_sw_we", wel, 0);
    check("unmapped_sw_stall", st_n, 0);
    idle();

    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h8040_0020; mem_data = 32'h1234_5678; mem_sel = 4'b1111;
    @(negedge clk);
    check("rstmid_we_low", ext_ram_we_n, 0);
    rst = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check("rstmid_ext_we_n", ext_ram_we_n, 1);
    check("rstmid_ext_ce_n", ext_ram_ce_n, 1);
    check("rstmid_base_ce_n", base_ram_ce_n, 1);
    check("rstmid_stall", stallreq_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_after_we_n", ext_ram_we_n, 1);
    check("rstmid_after_stall", stallreq_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
